// File: rtl/crg_gen_if.sv
// Host/PRNG/RAM bundle for the generation scheduler.
// slave = scheduler side, master = environment side.
interface crg_gen_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 32
);
  logic              start;
  logic [ADDR_W:0]   n_words;
  logic [CNT_W-1:0]  cnt_base;
  logic              prng_drdy;
  logic [CNT_W-1:0]  prng_cnt;
  logic              prng_dvld;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_vld;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, n_words, cnt_base,
    input  prng_dvld, rd_req, rd_addr,
    output prng_drdy, prng_cnt,
    output ram_we, ram_addr,
    output rd_gnt, rd_vld,
    output busy, done, err
  );

  modport master (
    output start, n_words, cnt_base,
    output prng_dvld, rd_req, rd_addr,
    input  prng_drdy, prng_cnt,
    input  ram_we, ram_addr,
    input  rd_gnt, rd_vld,
    input  busy, done, err
  );
endinterface

// File: rtl/crg_gen_scheduler.sv
// PRNG256 batch sequencer and result-RAM arbiter.
// Generator writes always win over host reads.
module crg_gen_scheduler #(
  parameter int ADDR_W   = 8,
  parameter int CNT_W    = 32,
  parameter int PRNG_LAT = 10,
  parameter int TMO      = 16
) (
  input  logic clk,
  input  logic rst_n,
  crg_gen_if.slave bus
);
  localparam int TLIM = PRNG_LAT + TMO;
  localparam int TW   = $clog2(TLIM + 1);
  localparam logic [ADDR_W:0] NMAX =
    (ADDR_W+1)'(2**ADDR_W);
  localparam logic [TW-1:0] TEND = TW'(TLIM - 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   iss_q, iss_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              err_q, err_d;
  logic              rvld_q;
  logic              busy, we, gnt, start_ok;

  assign busy = (state_q == ISSUE) ||
                (state_q == DRAIN);
  assign we = busy & bus.prng_dvld &
              (wcnt_q != n_q);
  assign gnt = rst_n & bus.rd_req & ~we;
  assign start_ok = (state_q == IDLE) &&
                    bus.start &&
                    (bus.n_words != '0) &&
                    (bus.n_words <= NMAX);

  assign bus.prng_drdy = (state_q == ISSUE);
  assign bus.prng_cnt  = cnt_q;
  assign bus.ram_we    = we;
  assign bus.ram_addr  = we  ? wptr_q :
                         gnt ? bus.rd_addr : '0;
  assign bus.rd_gnt    = gnt;
  assign bus.rd_vld    = rvld_q;
  assign bus.busy      = busy;
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;

  // next state, counters and sticky error
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    iss_d   = iss_q;
    wcnt_d  = wcnt_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    if (we) begin
      wcnt_d = wcnt_q + 1'b1;
      wptr_d = wptr_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = ISSUE;
          n_d     = bus.n_words;
          cnt_d   = bus.cnt_base;
          iss_d   = '0;
          wcnt_d  = '0;
          wptr_d  = '0;
          tmr_d   = '0;
          err_d   = 1'b0;
        end
      end
      ISSUE: begin
        iss_d = iss_q + 1'b1;
        if (iss_d == n_q) begin
          state_d = DRAIN;
          tmr_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        tmr_d = tmr_q + 1'b1;
        if (wcnt_d == n_q) begin
          state_d = DONE;
        end else if (tmr_q == TEND) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // rejected start, stray or surplus dvld
    if (bus.start && !start_ok) err_d = 1'b1;
    if (bus.prng_dvld && !we) err_d = 1'b1;
  end

  // state registers; reset aborts any batch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      iss_q   <= '0;
      wcnt_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      iss_q   <= iss_d;
      wcnt_q  <= wcnt_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      rvld_q  <= gnt;
    end
  end
endmodule

// File: tb/tb_crg_gen_scheduler.sv
// Directed bench for crg_gen_scheduler with
// PRNG latency-pipe and 1-cycle RAM models.
module tb_crg_gen_scheduler;
  localparam int LAT = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crg_gen_if #(.ADDR_W(8), .CNT_W(32)) bus ();

  crg_gen_scheduler #(
    .ADDR_W(8), .CNT_W(32),
    .PRNG_LAT(LAT), .TMO(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // PRNG model: fixed-latency pipe, optional drop
  logic [LAT-1:0] vpipe = '0;
  logic [31:0] cpipe [LAT];
  int beat = 0;
  int drop_idx = -1;
  logic [31:0] pcnt;
  assign pcnt = cpipe[LAT-1];
  assign bus.prng_dvld = vpipe[LAT-1];

  always @(posedge clk) begin
    vpipe <= {vpipe[LAT-2:0],
              bus.prng_drdy && (beat != drop_idx)};
    cpipe[0] <= bus.prng_cnt;
    for (int k = 1; k < LAT; k++)
      cpipe[k] <= cpipe[k-1];
    if (bus.start) beat <= 0;
    else if (bus.prng_drdy) beat <= beat + 1;
  end

  // single-port RAM model, write wins
  logic [255:0] mem [256];
  logic [255:0] dout;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= {8{pcnt}};
    else dout <= mem[bus.ram_addr];
  end

  // monitor, sampled mid-cycle
  logic [31:0] iss_q[$];
  logic [7:0]  we_q[$];
  int cyc = 0, done_total = 0, drain_total = 0;
  int done_cyc = 0, last_we_cyc = 0;
  logic done_busy = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.prng_drdy) iss_q.push_back(bus.prng_cnt);
    if (bus.ram_we) begin
      we_q.push_back(bus.ram_addr);
      last_we_cyc <= cyc;
    end
    if (bus.done) begin
      done_total <= done_total + 1;
      done_cyc <= cyc;
      done_busy <= bus.busy;
    end
    if (bus.busy && !bus.prng_drdy)
      drain_total <= drain_total + 1;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  int iss0, we0, dn0, dr0;
  task automatic snap();
    iss0 = iss_q.size();
    we0  = we_q.size();
    dn0  = done_total;
    dr0  = drain_total;
  endtask

  task automatic do_start(input int n,
                          input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.n_words = 9'(n);
    bus.cnt_base = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic check_batch(input string tag,
      input int n, input logic [31:0] b,
      input int nw, input logic e,
      input int drain, input logic ram_chk);
    int k, bad, ni, nwr;
    logic [31:0] ev;
    k = 0;
    while (done_total == dn0 && k < n + 200) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done"}, 64'(done_total - dn0), 1);
    ni = iss_q.size() - iss0;
    chk({tag, "_issues"}, 64'(ni), 64'(n));
    bad = 0;
    for (int i = 0; i < ni; i++) begin
      ev = b + 32'(i);
      if (iss_q[iss0+i] !== ev) bad++;
    end
    chk({tag, "_cnt_seq"}, 64'(bad), 0);
    nwr = we_q.size() - we0;
    chk({tag, "_writes"}, 64'(nwr), 64'(nw));
    bad = 0;
    for (int i = 0; i < nwr; i++)
      if (we_q[we0+i] !== 8'(i)) bad++;
    chk({tag, "_wr_addr"}, 64'(bad), 0);
    chk({tag, "_err"}, 64'(bus.err), 64'(e));
    chk({tag, "_busy_at_done"}, 64'(done_busy), 0);
    chk({tag, "_drain"}, 64'(drain_total - dr0),
        64'(drain));
    if (nw == n)
      chk({tag, "_done_gap"},
          64'(done_cyc - last_we_cyc), 1);
    if (ram_chk) begin
      bad = 0;
      for (int i = 0; i < n; i++) begin
        ev = b + 32'(i);
        if (mem[i][31:0] !== ev) bad++;
      end
      chk({tag, "_ram"}, 64'(bad), 0);
    end
  endtask

  typedef struct {
    int          n;
    logic [31:0] base;
    int          drop;
    logic        err;
    int          drain;
  } vec_t;
  vec_t tv [5];

  int k, wc, ovl, w;

  initial begin
    tv[0] = '{4,   32'h0000_0010, -1, 1'b0, 10};
    tv[1] = '{256, 32'hFFFF_FFFE, -1, 1'b0, 10};
    tv[2] = '{8,   32'h0000_0100,  3, 1'b1, 26};
    tv[3] = '{1,   32'h0000_0007, -1, 1'b0, 10};
    tv[4] = '{8,   32'h0000_0500, -1, 1'b0, 10};

    bus.start = 1'b0;
    bus.n_words = '0;
    bus.cnt_base = '0;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;

    #12;
    chk("reset_outs",
        64'({bus.prng_drdy, bus.prng_cnt, bus.ram_we,
             bus.ram_addr, bus.rd_gnt, bus.rd_vld,
             bus.busy, bus.done, bus.err}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      drop_idx = tv[v].drop;
      snap();
      do_start(tv[v].n, tv[v].base);
      check_batch($sformatf("vec%0d", v),
        tv[v].n, tv[v].base,
        (tv[v].drop >= 0) ? tv[v].n - 1 : tv[v].n,
        tv[v].err, tv[v].drain, tv[v].drop < 0);
    end
    drop_idx = -1;

    snap();
    do_start(0, 32'h55);
    repeat (3) @(posedge clk);
    #1;
    chk("n0_err", 64'(bus.err), 1);
    chk("n0_busy", 64'(bus.busy), 0);
    chk("n0_issues", 64'(iss_q.size() - iss0), 0);

    snap();
    do_start(3, 32'h300);
    k = 0;
    while (!bus.ram_we && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("arb_we_seen", 64'(bus.ram_we), 1);
    bus.rd_req = 1'b1;
    bus.rd_addr = 8'd5;
    wc = 0;
    ovl = 0;
    k = 0;
    while (k < 50) begin
      #1;
      if (bus.ram_we) wc++;
      if (bus.ram_we && bus.rd_gnt) ovl++;
      if (bus.rd_gnt) break;
      @(negedge clk);
      k++;
    end
    chk("arb_we_cycles", 64'(wc), 3);
    chk("arb_overlap", 64'(ovl), 0);
    chk("arb_gnt", 64'(bus.rd_gnt), 1);
    chk("arb_addr", 64'(bus.ram_addr), 5);
    chk("arb_vld_early", 64'(bus.rd_vld), 0);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("arb_vld", 64'(bus.rd_vld), 1);
    chk("arb_dout", 64'(dout[31:0]), 64'h505);
    @(negedge clk);
    chk("arb_vld_once", 64'(bus.rd_vld), 0);
    check_batch("arb", 3, 32'h300, 3, 1'b0, 10, 1'b1);

    snap();
    do_start(257, 32'h77);
    repeat (3) @(posedge clk);
    #1;
    chk("n257_err", 64'(bus.err), 1);
    chk("n257_issues", 64'(iss_q.size() - iss0), 0);

    snap();
    do_start(8, 32'h600);
    @(negedge clk);
    chk("mid_err_clr", 64'(bus.err), 0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.n_words = 9'd4;
    bus.cnt_base = 32'h900;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("mid_err_set", 64'(bus.err), 1);
    chk("mid_busy", 64'(bus.busy), 1);
    check_batch("mid", 8, 32'h600, 8, 1'b1, 10, 1'b1);

    snap();
    do_start(16, 32'h1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_issue_beat",
        64'(iss_q.size() - iss0), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_outs",
        64'({bus.prng_drdy, bus.prng_cnt, bus.ram_we,
             bus.ram_addr, bus.rd_gnt, bus.rd_vld,
             bus.busy, bus.done, bus.err}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w = we_q.size();
    repeat (20) @(negedge clk);
    chk("rst_no_we", 64'(we_q.size() - w), 0);
    chk("rst_stray_err", 64'(bus.err), 1);
    chk("rst_busy", 64'(bus.busy), 0);

    snap();
    do_start(4, 32'h2000);
    check_batch("post_rst", 4, 32'h2000, 4,
                1'b0, 10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/crg_gen_scheduler.md
Name: crg_gen_scheduler

Overview:
Sequences one batch of PRNG256 generation and shares the single-port 256x256 result RAM between generator writes and host (UART) reads. On start it issues a run of consecutive counter values to PRNG256 and writes each valid output to a RAM address derived from its own write pointer. It reports completion, and flags an error if the PRNG pipeline under-delivers. It sits between UART_CTRL and the PRNG256/singleport_ram pair.

Parameters:
ADDR_W, 8, RAM address width; depth = 2**ADDR_W words.
CNT_W, 32, PRNG counter width.
PRNG_LAT, 10, nominal cycles from Drdy to Dvld.
TMO, 16, extra drain cycles allowed beyond PRNG_LAT before timeout.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle batch start request.
n_words  in  ADDR_W+1  batch length, 1..2**ADDR_W; latched on accepted start.
cnt_base  in  CNT_W  first counter value; latched on accepted start.
prng_drdy  out  1  to PRNG256 Drdy.
prng_cnt  out  CNT_W  to PRNG256 cnt.
prng_dvld  in  1  from PRNG256 Dvld.
ram_we  out  1  RAM write enable; equals prng_dvld while accepting.
ram_addr  out  ADDR_W  RAM address: write pointer when ram_we=1, otherwise host address.
rd_req  in  1  host read request.
rd_addr  in  ADDR_W  host read address.
rd_gnt  out  1  read accepted this cycle.
rd_vld  out  1  RAM dout is valid; asserted exactly 1 cycle after rd_gnt.
busy  out  1  batch in progress.
done  out  1  one-cycle pulse on batch completion.
err  out  1  sticky error; cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including prng_cnt and ram_addr. Issue count, write count, write pointer and timer are 0. Reset mid-batch aborts immediately; no further RAM writes occur.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start with n_words in 1..2**ADDR_W: latch n_words and cnt_base, clear err, go to ISSUE. busy=1 from the next cycle.
  - start with n_words=0 or n_words>2**ADDR_W: set err, stay IDLE.
- Start while busy is ignored and sets err. The current batch continues.
- ISSUE: prng_drdy=1 for exactly N consecutive cycles, with prng_cnt = cnt_base+i for i=0..N-1 (modulo 2**CNT_W, wrap allowed). After the N-th issue cycle go to DRAIN. prng_cnt holds its last value while not issuing.
- Writes: any cycle with prng_dvld=1 while busy gives ram_we=1 and ram_addr=wr_ptr; then wr_ptr and the write count increment. wr_ptr restarts at 0 each batch.
  - Writes can begin while still in ISSUE, since PRNG_LAT < N is possible.
  - prng_dvld in IDLE is ignored (no write) and sets err.
  - A dvld after the write count reaches N is dropped and sets err.
- DRAIN: timer counts cycles since entry.
  - Write count reaching N: go to DONE.
  - Timer reaching PRNG_LAT+TMO with write count < N: set err, go to DONE.
- DONE: done=1 for one cycle, busy drops to 0 in the same cycle, next state IDLE.
- Arbitration: generator writes have absolute priority.
  - rd_gnt = rd_req & ~ram_we, combinational. Reads are allowed in any state, including during a batch.
  - An ungranted request must be held by the host.
  - rd_vld registers rd_gnt with 1-cycle latency, matching RAM read latency. RAM dout at that point reflects the addressed word.
  - A read of the address being written in the same cycle cannot occur, because write beats the read.
- busy=1 from the cycle after an accepted start through the cycle before done; busy=0 when done=1.

Test Plan:
- n_words=4, cnt_base=32'h0000_0010, PRNG_LAT=10 model -> prng_drdy high 4 cycles with cnt 0x10..0x13. RAM writes at addr 0..3 on dvld. done pulses 1 cycle after the 4th write. err=0.
- n_words=256, cnt_base=32'hFFFF_FFFE -> cnt sequence wraps 0xFFFFFFFE, 0xFFFFFFFF, 0x0, ... Writes to addresses 0..255, done, err=0.
- Host rd_req held at addr 5 while dvld is active for 3 cycles -> rd_gnt=0 during those cycles, rd_gnt=1 after them. rd_vld exactly 1 cycle after rd_gnt, with dout equal to word 5.
- PRNG model drops 1 of 8 dvld pulses, n_words=8 -> timeout after PRNG_LAT+16 drain cycles. err=1, done pulses, busy=0.
- start with n_words=0, and start again mid-batch -> err=1 each time, no state change. The mid-batch run still completes all N writes.
- rst_n asserted at the 3rd issue cycle of n_words=16 -> all outputs 0 asynchronously. No ram_we after deassertion. A new start runs normally from addr 0.
